// File: rtl/contador_garrafas_pkg.sv
// rtl/contador_garrafas_pkg.sv - shared constants and FSM encodings for the bottle counter
package contador_garrafas_pkg;

  localparam int CONT_W                  = 4;
  localparam int GARRAFAS_POR_DUZIA_DEF  = 12;
  localparam int DEBOUNCE_CYCLES_DEF     = 4;

  typedef logic [1:0] estado_t;

  localparam estado_t LIVRE        = 2'd0;
  localparam estado_t CONFIRMA_ON  = 2'd1;
  localparam estado_t OCUPADO      = 2'd2;
  localparam estado_t CONFIRMA_OFF = 2'd3;

endpackage

// File: rtl/contador_garrafas_filtro_sensor.sv
// rtl/contador_garrafas_filtro_sensor.sv - sensor synchronizer and debounce FSM
// det is a registered one-cycle strobe per accepted bottle arrival.
module filtro_sensor
  import contador_garrafas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_garrafa,
  output logic det
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit UM_CICLO = (DEBOUNCE_CYCLES == 1);

  logic          sync1_q, sync2_q;
  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          det_q, det_d;
  logic          s_sync;
  logic          estavel;

  assign s_sync  = sync2_q;
  assign estavel = UM_CICLO || (cnt_q == CNT_FIM);
  assign det     = det_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    det_d   = 1'b0;
    case (state_q)
      LIVRE: begin
        if (s_sync) begin
          state_d = CONFIRMA_ON;
          cnt_d   = CNT_UM;
        end
      end
      CONFIRMA_ON: begin
        if (!s_sync) begin
          state_d = LIVRE;
        end else if (estavel) begin
          state_d = OCUPADO;
          det_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end
      OCUPADO: begin
        if (!s_sync) begin
          state_d = CONFIRMA_OFF;
          cnt_d   = CNT_UM;
        end
      end
      CONFIRMA_OFF: begin
        // a returning level means the same bottle is still there: no new det
        if (s_sync) begin
          state_d = OCUPADO;
        end else if (estavel) begin
          state_d = LIVRE;
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end
      default: state_d = LIVRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LIVRE;
      cnt_q   <= '0;
      det_q   <= 1'b0;
    end else begin
      sync1_q <= sensor_garrafa;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
    end
  end

endmodule

// File: rtl/contador_garrafas.sv
// rtl/contador_garrafas.sv - bottle counter modulo one dozen with dozen pulse
// Optional total_garrafas output enabled by GARRAFA_TOTAL_EN.
module contador_garrafas
  import contador_garrafas_pkg::*;
#(
  parameter int GARRAFAS_POR_DUZIA = GARRAFAS_POR_DUZIA_DEF,
  parameter int DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_proc,
  input  logic              esteira_on,
  input  logic              sensor_garrafa,
  output logic [CONT_W-1:0] contagem_garrafas,
  output logic              garrafa_detectada,
  output logic              inc_duzia
`ifdef GARRAFA_TOTAL_EN
  ,
  output logic [15:0]       total_garrafas
`endif
);

  localparam logic [CONT_W-1:0] ULTIMA = CONT_W'(GARRAFAS_POR_DUZIA - 1);

  logic              det;
  logic              conta;
  logic [CONT_W-1:0] cnt_q, cnt_d;
  logic              gd_q, gd_d;
  logic              inc_q, inc_d;

  filtro_sensor #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_filtro (
    .clk           (clk),
    .reset         (reset),
    .sensor_garrafa(sensor_garrafa),
    .det           (det)
  );

  // start_proc wins over a simultaneous detection
  assign conta = det && esteira_on && !start_proc;

  always_comb begin
    cnt_d = cnt_q;
    gd_d  = 1'b0;
    inc_d = 1'b0;
    if (start_proc) begin
      cnt_d = '0;
    end else if (conta) begin
      gd_d = 1'b1;
      if (cnt_q == ULTIMA) begin
        cnt_d = '0;
        inc_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CONT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      gd_q  <= 1'b0;
      inc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      gd_q  <= gd_d;
      inc_q <= inc_d;
    end
  end

  assign contagem_garrafas = cnt_q;
  assign garrafa_detectada = gd_q;
  assign inc_duzia         = inc_q;

`ifdef GARRAFA_TOTAL_EN
  logic [15:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (conta && (total_q != 16'hFFFF)) begin
      total_d = total_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign total_garrafas = total_q;
`endif

endmodule

// File: tb/tb_contador_garrafas.sv
// tb/tb_contador_garrafas.sv - directed self-checking bench for contador_garrafas
module tb_contador_garrafas;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_proc;
  logic       esteira_on;
  logic       sensor_garrafa;
  logic [3:0] contagem_garrafas;
  logic       garrafa_detectada;
  logic       inc_duzia;
`ifdef GARRAFA_TOTAL_EN
  logic [15:0] total_garrafas;
`endif

  int checks = 0;
  int errors = 0;
  int gd_n   = 0;
  int inc_n  = 0;
  int base;
  int ibase;

  contador_garrafas dut (
    .clk              (clk),
    .reset            (reset),
    .start_proc       (start_proc),
    .esteira_on       (esteira_on),
    .sensor_garrafa   (sensor_garrafa),
    .contagem_garrafas(contagem_garrafas),
    .garrafa_detectada(garrafa_detectada),
    .inc_duzia        (inc_duzia)
`ifdef GARRAFA_TOTAL_EN
    ,
    .total_garrafas   (total_garrafas)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pulse counters and the dozen/bottle coincidence rule
  always @(negedge clk) begin
    if (garrafa_detectada === 1'b1) gd_n++;
    if (inc_duzia === 1'b1) begin
      inc_n++;
      chk("inc_with_gd", {31'd0, garrafa_detectada}, 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bottle(input int hi, input int lo);
    sensor_garrafa = 1'b1;
    step(hi);
    sensor_garrafa = 1'b0;
    step(lo);
  endtask

  initial begin
    reset          = 1'b1;
    start_proc     = 1'b0;
    esteira_on     = 1'b0;
    sensor_garrafa = 1'b0;
    step(3);
    chk("rst_count", {28'd0, contagem_garrafas}, 32'd0);
    chk("rst_gd", {31'd0, garrafa_detectada}, 32'd0);
    chk("rst_inc", {31'd0, inc_duzia}, 32'd0);
    reset = 1'b0;

    // reset in the middle of a held bottle
    esteira_on     = 1'b1;
    sensor_garrafa = 1'b1;
    step(20);
    chk("pre_reset_count", {28'd0, contagem_garrafas}, 32'd1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("reset_cycle_count", {28'd0, contagem_garrafas}, 32'd0);
    chk("reset_cycle_gd", {31'd0, garrafa_detectada}, 32'd0);
    base = gd_n;
    step(6);
    chk("post_reset_quiet", base == gd_n ? 32'd0 : 32'd1, 32'd0);
    chk("post_reset_gd_low", {31'd0, garrafa_detectada}, 32'd0);
    step(1);
    chk("post_reset_gd", {31'd0, garrafa_detectada}, 32'd1);
    chk("post_reset_count", {28'd0, contagem_garrafas}, 32'd1);
    sensor_garrafa = 1'b0;
    step(12);
    start_proc = 1'b1;
    step(1);
    start_proc = 1'b0;
    chk("start_clear", {28'd0, contagem_garrafas}, 32'd0);

    // single bottle latency
    base = gd_n;
    sensor_garrafa = 1'b1;
    step(6);
    chk("lat_early_gd", {31'd0, garrafa_detectada}, 32'd0);
    chk("lat_early_count", {28'd0, contagem_garrafas}, 32'd0);
    step(1);
    chk("lat_gd", {31'd0, garrafa_detectada}, 32'd1);
    chk("lat_count", {28'd0, contagem_garrafas}, 32'd1);
    chk("lat_inc", {31'd0, inc_duzia}, 32'd0);
    step(1);
    chk("gd_one_cycle", {31'd0, garrafa_detectada}, 32'd0);
    step(2);
    sensor_garrafa = 1'b0;
    step(10);
    chk("single_pulses", 32'(gd_n - base), 32'd1);

    // short glitch rejected
    base = gd_n;
    bottle(3, 10);
    chk("glitch_count", {28'd0, contagem_garrafas}, 32'd1);
    chk("glitch_pulses", 32'(gd_n - base), 32'd0);

    // low dip inside a held bottle
    base = gd_n;
    sensor_garrafa = 1'b1;
    step(4);
    sensor_garrafa = 1'b0;
    step(2);
    sensor_garrafa = 1'b1;
    step(4);
    sensor_garrafa = 1'b0;
    step(12);
    chk("dip_count", {28'd0, contagem_garrafas}, 32'd2);
    chk("dip_pulses", 32'(gd_n - base), 32'd1);

    // conveyor stopped for bottle 3
    base = gd_n;
    esteira_on = 1'b0;
    bottle(10, 10);
    esteira_on = 1'b1;
    chk("esteira_off_count", {28'd0, contagem_garrafas}, 32'd2);
    chk("esteira_off_pulses", 32'(gd_n - base), 32'd0);

    start_proc = 1'b1;
    step(1);
    start_proc = 1'b0;

    // two dozen clean bottles
    ibase = inc_n;
    for (int i = 0; i < 24; i++) begin
      bottle(10, 10);
      chk($sformatf("dozen_count_%0d", i + 1), {28'd0, contagem_garrafas}, 32'((i + 1) % 12));
      if (i == 11) chk("inc_after_12", 32'(inc_n - ibase), 32'd1);
    end
    chk("inc_after_24", 32'(inc_n - ibase), 32'd2);

    // start_proc coincident with the det that would complete a dozen
    for (int i = 0; i < 11; i++) bottle(10, 10);
    chk("pre_start_count", {28'd0, contagem_garrafas}, 32'd11);
    ibase = inc_n;
    base  = gd_n;
    sensor_garrafa = 1'b1;
    step(6);
    start_proc = 1'b1;
    step(1);
    start_proc = 1'b0;
    chk("start_det_count", {28'd0, contagem_garrafas}, 32'd0);
    chk("start_det_gd", {31'd0, garrafa_detectada}, 32'd0);
    chk("start_det_inc", {31'd0, inc_duzia}, 32'd0);
    step(3);
    sensor_garrafa = 1'b0;
    step(10);
    chk("start_det_no_inc", 32'(inc_n - ibase), 32'd0);
    chk("start_det_no_gd", 32'(gd_n - base), 32'd0);
    chk("start_det_not_recounted", {28'd0, contagem_garrafas}, 32'd0);

`ifdef GARRAFA_TOTAL_EN
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    chk("total_rst", {16'd0, total_garrafas}, 32'd0);
    for (int i = 0; i < 5; i++) bottle(10, 10);
    start_proc = 1'b1;
    step(1);
    start_proc = 1'b0;
    for (int i = 0; i < 25; i++) bottle(10, 10);
    chk("total_30", {16'd0, total_garrafas}, 32'd30);
    chk("total_count", {28'd0, contagem_garrafas}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_garrafas.md
Name: contador_garrafas

Overview:
- Upstream neighbour of the dozen counter on the wine-bottle conveyor.
- Conditions the raw optical bottle sensor: 2-FF synchronizer, debounce FSM, then one detection per physical bottle.
- Counts bottles modulo GARRAFAS_POR_DUZIA and emits a one-cycle inc_duzia pulse per completed dozen; inc_duzia drives the dozen counter's inc.

Parameters:
- GARRAFAS_POR_DUZIA, 12: bottles per dozen. Legal range 2..15, since the count is 4 bits.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a sensor level change. Must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start_proc  input  1  synchronous clear of the bottle count; same signal as the dozen counter's start_proc.
- esteira_on  input  1  conveyor running; qualifies counting.
- sensor_garrafa  input  1  raw asynchronous sensor, high = bottle present.
- contagem_garrafas  output  4  bottles in the current dozen, 0..GARRAFAS_POR_DUZIA-1.
- garrafa_detectada  output  1  one-cycle pulse per accepted, counted bottle.
- inc_duzia  output  1  one-cycle pulse when a dozen completes.

Behaviour:
- Reset and clock: one clock domain, clk. Reset is synchronous, active-high.
  - While reset is high: sync flops = 0, FSM = LIVRE, debounce counter = 0, contagem_garrafas = 0, garrafa_detectada = 0, inc_duzia = 0.
  - Reset asserted mid-operation discards any partial debounce and the count. No pulse is emitted in the reset cycle.
- Synchronizer: sensor_garrafa passes through 2 flops to give s_sync. All FSM decisions use s_sync only.
- Debounce FSM, 4 states:
  - LIVRE: s_sync=1 → CONFIRMA_ON, debounce counter = 1.
  - CONFIRMA_ON:
    - s_sync=0 → LIVRE.
    - s_sync=1 with counter = DEBOUNCE_CYCLES-1 → OCUPADO and raise internal detection strobe det.
    - Otherwise increment the counter.
  - OCUPADO: s_sync=0 → CONFIRMA_OFF, counter = 1.
  - CONFIRMA_OFF:
    - s_sync=1 → OCUPADO, with no new detection.
    - s_sync=0 with counter = DEBOUNCE_CYCLES-1 → LIVRE.
    - Otherwise increment the counter.
  - DEBOUNCE_CYCLES=1: the CONFIRMA states are left after a single cycle.
  - Glitches shorter than DEBOUNCE_CYCLES produce no detection. A bottle held under the sensor produces exactly one detection.
- Latency: garrafa_detectada rises 2 + DEBOUNCE_CYCLES + 1 cycles after the first clk edge sampling sensor high. That is 7 cycles at default.
- Counting, evaluated in the cycle det is raised; all outputs are registered:
  - start_proc=1: count ← 0, no pulses. start_proc overrides det in the same cycle.
  - det=1 and esteira_on=0: detection dropped, no count change, no pulses. The FSM still advances to OCUPADO.
  - det=1 and esteira_on=1, count < GARRAFAS_POR_DUZIA-1: count+1, garrafa_detectada=1.
  - det=1 and esteira_on=1, count = GARRAFAS_POR_DUZIA-1: count ← 0, garrafa_detectada=1, inc_duzia=1 in the same cycle.
- Pulse rules:
  - Both pulses last exactly one cycle.
  - inc_duzia never fires without garrafa_detectada.
  - Pulses are separated by at least 2·DEBOUNCE_CYCLES cycles.
- start_proc does not affect the FSM. A bottle already present stays OCUPADO and is not recounted.

Optional Feature:
- Macro: GARRAFA_TOTAL_EN.
- Defined: adds output total_garrafas [15:0], a count of every counted bottle.
  - Saturates at 16'hFFFF.
  - Cleared by reset only, not by start_proc.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package contador_garrafas_pkg:
  - FSM state enum: LIVRE, CONFIRMA_ON, OCUPADO, CONFIRMA_OFF.
  - Default constants for GARRAFAS_POR_DUZIA and DEBOUNCE_CYCLES.
  - Count width constant (4).
- One sub-module, filtro_sensor: synchronizer plus debounce FSM. Inputs clk, reset, sensor_garrafa; output det.
- Top level: count/wrap logic, start_proc handling, optional total counter.

Test Plan:
- Reset: defaults, sensor high for 20 cycles, then reset for 1 cycle → count 0, no pulses during or after the reset cycle until a fresh debounce completes.
- Single bottle: defaults, esteira_on=1, sensor high 10 cycles → garrafa_detectada one pulse 7 cycles after the first high sample; count 0→1; inc_duzia 0.
- Glitch rejection: sensor high 3 cycles, then low; also a 2-cycle low dip inside a 10-cycle high → no extra detection; count unchanged.
- Dozen wrap: 12 clean bottles, 10 cycles high / 10 low each → count 1..11 then 0; inc_duzia exactly one pulse, coincident with the 12th garrafa_detectada; 24 bottles → 2 inc_duzia pulses.
- Conveyor off / start_proc:
  - esteira_on=0 for bottle 3 → count stays 2.
  - start_proc in the cycle det fires at count 11 → count 0, no inc_duzia.
- GARRAFA_TOTAL_EN: 30 bottles with start_proc pulsed after bottle 5 → total_garrafas = 30, contagem_garrafas = 1.
